// File: rtl/cmb_arbiter_if.sv
// Requester-side and datapath-side signals of the shared result-check arbiter.
// master = requesters plus the external datapath; slave = the arbiter itself.
interface cmb_arbiter_if;
    logic [3:0]  req;
    logic [15:0] word0;
    logic [15:0] word1;
    logic [15:0] word2;
    logic [15:0] word3;
    logic [15:0] dp_in;
    logic [3:0]  dp_out;
    logic [3:0]  gnt;
    logic        busy;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [3:0]  resp_data;
    logic [15:0] txn_count;

    modport master (
        output req, word0, word1, word2, word3, dp_out,
        input  dp_in, gnt, busy, resp_valid, resp_id, resp_data, txn_count
    );

    modport slave (
        input  req, word0, word1, word2, word3, dp_out,
        output dp_in, gnt, busy, resp_valid, resp_id, resp_data, txn_count
    );
endinterface

// File: rtl/cmb_arbiter.sv
// Round-robin arbiter that time-shares one combinational datapath among four requesters,
// holding the winner's operand for SETTLE cycles before sampling the 4-bit result.
module cmb_arbiter #(
    parameter int unsigned SETTLE = 1
) (
    input logic          clock,
    input logic          reset,
    cmb_arbiter_if.slave bus
);

    typedef enum logic {StIdle, StHold} state_e;

    localparam logic [3:0] CntReload = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  id_q, id_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] dp_in_q, dp_in_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic [1:0]  resp_id_q, resp_id_d;
    logic [3:0]  resp_data_q, resp_data_d;
    logic [15:0] txn_count_q, txn_count_d;

    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        found;
    logic [15:0] word_sel;

    // Scan upward from ptr+1; the last candidate (offset 4) is ptr itself.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned off = 1; off <= 4; off++) begin
            cand = ptr_q + off[1:0];
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        word_sel = bus.word0;
        unique case (winner)
            2'd0: word_sel = bus.word0;
            2'd1: word_sel = bus.word1;
            2'd2: word_sel = bus.word2;
            2'd3: word_sel = bus.word3;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        dp_in_d      = dp_in_q;
        gnt_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        txn_count_d  = txn_count_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StHold;
                    dp_in_d = word_sel;
                    id_d    = winner;
                    gnt_d   = 4'b0001 << winner;
                    ptr_d   = winner;
                    cnt_d   = CntReload;
                end
            end
            StHold: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // dp_in has been stable for SETTLE cycles; dp_out is trusted now.
                    resp_data_d  = bus.dp_out;
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    txn_count_d  = txn_count_q + 16'd1;
                    state_d      = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= 2'd3;
            id_q         <= '0;
            cnt_q        <= '0;
            dp_in_q      <= '0;
            gnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            txn_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            dp_in_q      <= dp_in_d;
            gnt_q        <= gnt_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            txn_count_q  <= txn_count_d;
        end
    end

    assign bus.dp_in      = dp_in_q;
    assign bus.gnt        = gnt_q;
    assign bus.busy       = (state_q == StHold);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.txn_count  = txn_count_q;

endmodule

// File: tb/tb_cmb_arbiter.sv
// Bench for cmb_arbiter: SETTLE=1 and SETTLE=4 instances, a transaction-level model
// compared every cycle, and directed vectors with literal expectations.
module tb_cmb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmb_arbiter_if if1 ();
    cmb_arbiter_if if4 ();

    cmb_arbiter #(.SETTLE(1)) u_dut1 (.clock(clk), .reset(rst), .bus(if1.slave));
    cmb_arbiter #(.SETTLE(4)) u_dut4 (.clock(clk), .reset(rst), .bus(if4.slave));

    // Stand-in datapath: pq = all ones, pr = parity, ps = pp, pt = all zeros.
    function automatic logic [3:0] golden(input logic [15:0] w);
        return {~|w, w[15], ^w, &w};
    endfunction

    logic [3:0] inj4;
    assign if1.dp_out = golden(if1.dp_in);
    assign if4.dp_out = golden(if4.dp_in) ^ inj4;

    int n_vec = 0;
    int n_bad = 0;

    // Literal expectations posted by the stimulus, checked at the end of the same cycle.
    // kind: 0 {resp_valid,resp_id,resp_data}, 1 txn_count, 2 gnt, 3 dp_in, 4 busy
    logic [4:0]  pin_en  [2];
    logic [15:0] pin_val [2][5];
    logic        do_preload;
    string pin_nm [5] = '{"pin_resp", "pin_txn", "pin_gnt", "pin_dp_in", "pin_busy"};

    task automatic chk(input int k, input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s: got %h want %h at %0t", k, nm, act, exp, $time);
        end
    endtask

    // Model state: remaining hold cycles instead of an FSM.
    int unsigned settle [2] = '{1, 4};
    int unsigned left   [2];
    int unsigned ptr    [2];
    logic [1:0]  id     [2];
    logic [3:0]  e_gnt  [2];
    logic        e_busy [2];
    logic [15:0] e_dp   [2];
    logic        e_rv   [2];
    logic [1:0]  e_rid  [2];
    logic [3:0]  e_rd   [2];
    logic [15:0] e_txn  [2];
    logic        armed = 1'b0;

    always @(negedge clk) begin
        logic        armed_now;
        logic [3:0]  req_k;
        logic [15:0] w_k [4];
        logic [3:0]  dpo_k;
        logic [3:0]  o_gnt;
        logic        o_busy;
        logic [15:0] o_dp;
        logic        o_rv;
        logic [1:0]  o_rid;
        logic [3:0]  o_rd;
        logic [15:0] o_txn;
        int unsigned c;
        logic        hit;
        armed_now = armed;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                req_k = if1.req; dpo_k = if1.dp_out;
                w_k[0] = if1.word0; w_k[1] = if1.word1; w_k[2] = if1.word2; w_k[3] = if1.word3;
                o_gnt = if1.gnt; o_busy = if1.busy; o_dp = if1.dp_in; o_rv = if1.resp_valid;
                o_rid = if1.resp_id; o_rd = if1.resp_data; o_txn = if1.txn_count;
            end else begin
                req_k = if4.req; dpo_k = if4.dp_out;
                w_k[0] = if4.word0; w_k[1] = if4.word1; w_k[2] = if4.word2; w_k[3] = if4.word3;
                o_gnt = if4.gnt; o_busy = if4.busy; o_dp = if4.dp_in; o_rv = if4.resp_valid;
                o_rid = if4.resp_id; o_rd = if4.resp_data; o_txn = if4.txn_count;
            end
            if (armed_now) begin
                if (k == 0 && do_preload) e_txn[0] = 16'hFFFF;
                chk(k, "gnt", {12'd0, o_gnt}, {12'd0, e_gnt[k]});
                chk(k, "busy", {15'd0, o_busy}, {15'd0, e_busy[k]});
                chk(k, "dp_in", o_dp, e_dp[k]);
                chk(k, "resp_valid", {15'd0, o_rv}, {15'd0, e_rv[k]});
                chk(k, "resp_id", {14'd0, o_rid}, {14'd0, e_rid[k]});
                chk(k, "resp_data", {12'd0, o_rd}, {12'd0, e_rd[k]});
                chk(k, "txn_count", o_txn, e_txn[k]);
                for (int p = 0; p < 5; p++) begin
                    if (pin_en[k][p]) begin
                        case (p)
                            0: chk(k, pin_nm[p], {9'd0, o_rv, o_rid, o_rd}, pin_val[k][p]);
                            1: chk(k, pin_nm[p], o_txn, pin_val[k][p]);
                            2: chk(k, pin_nm[p], {12'd0, o_gnt}, pin_val[k][p]);
                            3: chk(k, pin_nm[p], o_dp, pin_val[k][p]);
                            default: chk(k, pin_nm[p], {15'd0, o_busy}, pin_val[k][p]);
                        endcase
                    end
                end
            end
            // Expectations for the next cycle, from the inputs of this one.
            if (rst) begin
                armed = 1'b1;
                left[k] = 0; ptr[k] = 3; id[k] = '0;
                e_gnt[k] = '0; e_busy[k] = 1'b0; e_dp[k] = '0; e_rv[k] = 1'b0;
                e_rid[k] = '0; e_rd[k] = '0; e_txn[k] = '0;
            end else begin
                e_gnt[k] = '0;
                e_rv[k]  = 1'b0;
                if (left[k] == 0) begin
                    hit = 1'b0;
                    for (int off = 1; off <= 4; off++) begin
                        c = (ptr[k] + off) % 4;
                        if (!hit && req_k[c]) begin
                            hit = 1'b1;
                            e_gnt[k] = 4'b0001 << c;
                            e_dp[k]  = w_k[c];
                            id[k]    = 2'(c);
                            ptr[k]   = c;
                        end
                    end
                    left[k]   = hit ? settle[k] : 0;
                    e_busy[k] = hit;
                end else if (left[k] == 1) begin
                    e_rd[k]   = dpo_k;
                    e_rid[k]  = id[k];
                    e_rv[k]   = 1'b1;
                    e_txn[k]  = e_txn[k] + 16'd1;
                    e_busy[k] = 1'b0;
                    left[k]   = 0;
                end else begin
                    left[k] = left[k] - 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        pin_en[0] = '0;
        pin_en[1] = '0;
    endtask

    task automatic pin(input int d, input int kind, input logic [15:0] v);
        pin_en[d][kind] = 1'b1;
        pin_val[d][kind] = v;
    endtask

    logic [3:0] order [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};

    initial begin
        rst = 1'b1; inj4 = '0; do_preload = 1'b0;
        pin_en[0] = '0; pin_en[1] = '0;
        if1.req = '0; if1.word0 = '0; if1.word1 = '0; if1.word2 = '0; if1.word3 = '0;
        if4.req = '0; if4.word0 = '0; if4.word1 = '0; if4.word2 = '0; if4.word3 = '0;
        step(); step();
        rst = 1'b0;
        step();

        // Single request, SETTLE=1, all-ones operand.
        if1.word0 = 16'hFFFF; if1.req = 4'b0001;
        step();
        pin(0, 2, 16'h0001); pin(0, 3, 16'hFFFF); if1.req = '0;
        step();
        pin(0, 0, 16'h0045); pin(0, 1, 16'h0001);

        // Requester 2 with all-zero operand, accepted in the resp_valid cycle.
        if1.word2 = 16'h0000; if1.req = 4'b0100;
        step();
        if1.req = '0;
        step();
        pin(0, 0, 16'h0068); pin(0, 1, 16'h0002);
        step();

        // All four held: ptr=2 so order is 3,0,1,2.
        if1.word0 = 16'hA001; if1.word1 = 16'hB002; if1.word2 = 16'hC004; if1.word3 = 16'hD008;
        if1.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i % 2 == 0) pin(0, 2, {12'd0, order[i / 2]});
            else pin(0, 1, 16'(3 + i / 2));
        end
        if1.req = '0;
        repeat (3) step();

        // SETTLE=4 with dp_out disturbed during the hold window.
        if4.word1 = 16'h1234; if4.req = 4'b0010;
        step();
        pin(1, 2, 16'h0002); pin(1, 4, 16'h0001); if4.req = '0;
        step();
        inj4 = 4'hF; pin(1, 4, 16'h0001);
        step();
        inj4 = 4'h3;
        step();
        inj4 = 4'h5; pin(1, 3, 16'h1234); pin(1, 4, 16'h0001);
        step();
        pin(1, 0, 16'h0057); pin(1, 1, 16'h0001); inj4 = '0;
        step();

        // Reset in cycle 2 of a SETTLE=4 transaction.
        step();
        if4.req = 4'b0010;
        step();
        if4.req = '0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pin(1, 0, 16'h0000); pin(1, 1, 16'h0000); pin(1, 3, 16'h0000); pin(1, 4, 16'h0000);
        if4.req = 4'b1111;
        step();
        pin(1, 2, 16'h0001); if4.req = '0;
        repeat (6) step();

        // Counter wrap: preload 0xFFFF then complete one more.
        force u_dut1.txn_count_q = 16'hFFFF;
        do_preload = 1'b1;
        @(posedge clk);
        #1;
        release u_dut1.txn_count_q;
        do_preload = 1'b0;
        #1;
        if1.word0 = 16'h0F0F; if1.req = 4'b0001;
        step();
        if1.req = '0; pin(0, 1, 16'hFFFF);
        step();
        pin(0, 1, 16'h0000); pin(0, 0, 16'h0040);
        step();
        step();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
